dco_code_slewer: RTL and testbench
==================================

Name: dco_code_slewer

Overview:
- Parametrised control front-end for the next-generation DCO.
- Converts a binary coarse target code into the DCO thermometer control word. Also delivers a binary fine code.
- Moves the coarse code toward the target in bounded, settle-spaced steps, so the DCO period never jumps by more than STEP_MAX cells at once.
- Sits between the DLL/ADPLL loop filter (req/ack side) and the DCO coarse/fine control inputs.

Parameters:
- CW, 7: binary coarse code width. Thermometer width TW = 2**CW-1 (127 cells at default).
- FW, 3: binary fine code width.
- STEP_MAX, 1: maximum coarse code change per step, >=1.
- SETTLE_CYC, 4: clk edges spent in WAIT after each step, >=1.
- DITHER_DIV, 8: fine dither toggle interval in clk edges. Used only with DCO_DITHER_EN.

Ports:
- clk  input  1  control clock, rising edge.
- reset_  input  1  reset, asynchronous, active-high.
- req  input  1  new target request, sampled in IDLE only.
- code_target  input  CW  binary coarse target, 0..2**CW-1.
- fine_target  input  FW  binary fine target.
- ack  output  1  one-cycle pulse: target reached, fine applied.
- busy  output  1  high from acceptance until the ack edge.
- cur_code  output  CW  current binary coarse code.
- coarse_therm  output  TW  thermometer control word; bit i = (i < cur_code).
- fine_bin  output  FW  fine control code to DCO.
- dither_en  input  1  present only with DCO_DITHER_EN.

Behaviour:
- Reset (reset_=1, async):
  - cur_code=0, coarse_therm=0, fine_bin=0, ack=0, busy=0, state=IDLE, settle counter=0.
  - Latched targets are cleared, and any in-progress slew is abandoned.
- All outputs are registered. coarse_therm is updated on the same edge as cur_code.
- States: IDLE, SLEW, WAIT.
- IDLE:
  - ack<=0.
  - If req=1, latch code_target into tgt and fine_target into ftgt; busy<=1; go to SLEW. This is acceptance edge E0.
- SLEW:
  - If cur_code==tgt: fine_bin<=ftgt, ack<=1, busy<=0, go to IDLE.
  - Otherwise: cur_code moves toward tgt by min(STEP_MAX, |tgt-cur_code|); the step never overshoots. Load cnt<=SETTLE_CYC-1 and go to WAIT.
- WAIT:
  - If cnt==0, go to SLEW; else cnt<=cnt-1.
  - Each step therefore occupies SETTLE_CYC+1 edges.
- Latency:
  - With distance d and STEP_MAX=1, ack rises on edge E0+1+d*(SETTLE_CYC+1).
  - For d=0, ack rises on edge E0+1.
  - ack falls on the following edge.
- req while busy=1, or on the ack edge, is ignored (not queued). A new req is accepted on the first edge where state=IDLE.
- Direction is decided per step using unsigned compare. No wrap-around: cur_code stays within 0..2**CW-1.
- fine_bin changes only on the ack edge, never mid-slew.
- Reset asserted mid-slew forces all reset values immediately. After release, the block waits in IDLE for a new req.

Optional Feature:
- Macro: DCO_DITHER_EN.
- With the macro defined:
  - Port dither_en exists.
  - While state=IDLE and dither_en=1, fine_bin alternates between ftgt and min(ftgt+1, 2**FW-1) every DITHER_DIV edges, using a free counter that is cleared on reset and on leaving IDLE.
  - When dither_en=0 or state!=IDLE, fine_bin=ftgt.
- Without the macro: no dither_en port, no dither counter; fine_bin is static between acks.

Test Plan:
1. Reset: hold reset_=1 mid-simulation with arbitrary inputs -> immediately cur_code=0, coarse_therm=0, fine_bin=0, ack=0, busy=0.
2. Up-slew, defaults: from 0, req with code_target=3, fine_target=5 -> cur_code 1,2,3 at E0+1, E0+6, E0+11. ack pulse at E0+16. coarse_therm=0x7 and fine_bin=5 at ack.
3. Down-slew with STEP_MAX=8: from cur_code=127, target 110 -> steps to 119, 111, 110 (last step clipped). coarse_therm has exactly 110 ones at ack.
4. Zero distance: req with code_target equal to cur_code, fine_target=2 -> ack at E0+1, coarse_therm unchanged, fine_bin=2.
5. Busy collision: second req with code_target=0 during a slew to 20 -> ignored. Slew completes at 20 with a single ack pulse.
6. Mid-slew reset: assert reset_ after the 2nd step toward 50 -> outputs zero at once. After release, no ack until a new req.

Source files
------------

// File: rtl/dco_code_slewer.sv
// DCO coarse/fine control front-end: slews a binary coarse code toward a target in
// bounded, settle-spaced steps and drives the thermometer word. Optional fine dither: DCO_DITHER_EN.
module dco_code_slewer #(
  parameter  int CW         = 7,
  parameter  int FW         = 3,
  parameter  int STEP_MAX   = 1,
  parameter  int SETTLE_CYC = 4,
  parameter  int DITHER_DIV = 8,
  localparam int TW         = (2 ** CW) - 1
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          req,
  input  logic [CW-1:0] code_target,
  input  logic [FW-1:0] fine_target,
`ifdef DCO_DITHER_EN
  input  logic          dither_en,
`endif
  output logic          ack,
  output logic          busy,
  output logic [CW-1:0] cur_code,
  output logic [TW-1:0] coarse_therm,
  output logic [FW-1:0] fine_bin
);

  localparam int CNTW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int STEP_CLAMP = (STEP_MAX > TW) ? TW : STEP_MAX;

  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]   STEP_L   = CW'(STEP_CLAMP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLEW = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   cur_q, cur_d;
  logic [CW-1:0]   tgt_q, tgt_d;
  logic [FW-1:0]   ftgt_q, ftgt_d;
  logic [TW-1:0]   therm_q, therm_d;
  logic [FW-1:0]   fine_q, fine_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;

  function automatic logic [TW-1:0] therm_of(input logic [CW-1:0] code);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < TW; i++) begin
      t[i] = (i < int'(code));
    end
    return t;
  endfunction

  // Clipped step: never moves further than the remaining distance.
  function automatic logic [CW-1:0] step_toward(input logic [CW-1:0] cur,
                                                input logic [CW-1:0] tgt);
    logic [CW-1:0] res;
    if (tgt > cur) begin
      if ((tgt - cur) > STEP_L) begin
        res = cur + STEP_L;
      end else begin
        res = tgt;
      end
    end else begin
      if ((cur - tgt) > STEP_L) begin
        res = cur - STEP_L;
      end else begin
        res = tgt;
      end
    end
    return res;
  endfunction

`ifdef DCO_DITHER_EN
  localparam int DW = (DITHER_DIV > 1) ? $clog2(DITHER_DIV) : 1;
  localparam logic [DW-1:0] DITH_LAST = DW'(DITHER_DIV - 1);

  logic [DW-1:0] dith_cnt_q, dith_cnt_d;
  logic          dith_ph_q, dith_ph_d;
  logic [FW-1:0] fbase_q, fbase_d;

  function automatic logic [FW-1:0] fine_bump(input logic [FW-1:0] f);
    logic [FW-1:0] r;
    if (f == {FW{1'b1}}) begin
      r = f;
    end else begin
      r = f + FW'(1);
    end
    return r;
  endfunction
`endif

  // Next-state and next-output computation for the slew controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    ftgt_d  = ftgt_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
`ifdef DCO_DITHER_EN
    fbase_d = fbase_q;
`else
    fine_d  = fine_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          tgt_d   = code_target;
          ftgt_d  = fine_target;
          busy_d  = 1'b1;
          state_d = ST_SLEW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SLEW: begin
        if (cur_q == tgt_q) begin
`ifdef DCO_DITHER_EN
          fbase_d = ftgt_q;
`else
          fine_d  = ftgt_q;
`endif
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cur_d   = step_toward(cur_q, tgt_q);
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_SLEW;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    therm_d = therm_of(cur_d);
  end

`ifdef DCO_DITHER_EN
  // Dither phase only runs while parked in IDLE; it is based on the last applied fine code.
  always_comb begin
    dith_cnt_d = dith_cnt_q;
    dith_ph_d  = dith_ph_q;
    if ((state_d != ST_IDLE) || (state_q != ST_IDLE) || !dither_en) begin
      dith_cnt_d = '0;
      dith_ph_d  = 1'b0;
    end else if (dith_cnt_q == DITH_LAST) begin
      dith_cnt_d = '0;
      dith_ph_d  = ~dith_ph_q;
    end else begin
      dith_cnt_d = dith_cnt_q + DW'(1);
    end
    if (dith_ph_d) begin
      fine_d = fine_bump(fbase_d);
    end else begin
      fine_d = fbase_d;
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_q      <= '0;
      tgt_q      <= '0;
      ftgt_q     <= '0;
      therm_q    <= '0;
      fine_q     <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DCO_DITHER_EN
      dith_cnt_q <= '0;
      dith_ph_q  <= 1'b0;
      fbase_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      ftgt_q     <= ftgt_d;
      therm_q    <= therm_d;
      fine_q     <= fine_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
`ifdef DCO_DITHER_EN
      dith_cnt_q <= dith_cnt_d;
      dith_ph_q  <= dith_ph_d;
      fbase_q    <= fbase_d;
`endif
    end
  end

  assign ack          = ack_q;
  assign busy         = busy_q;
  assign cur_code     = cur_q;
  assign coarse_therm = therm_q;
  assign fine_bin     = fine_q;

endmodule

// File: tb/tb_dco_code_slewer.sv
// Directed bench for dco_code_slewer: default instance (STEP_MAX=1) and a STEP_MAX=8 instance.
module tb_dco_code_slewer;

  logic         clk = 1'b0;
  logic         reset_;
  logic         req_a, req_b;
  logic [6:0]   ct_a, ct_b;
  logic [2:0]   ft_a, ft_b;
  logic         ack_a, ack_b, busy_a, busy_b;
  logic [6:0]   cur_a, cur_b;
  logic [126:0] therm_a, therm_b;
  logic [2:0]   fine_a, fine_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dco_code_slewer u_dut_a (
    .clk(clk), .reset_(reset_), .req(req_a), .code_target(ct_a), .fine_target(ft_a),
    .ack(ack_a), .busy(busy_a), .cur_code(cur_a), .coarse_therm(therm_a), .fine_bin(fine_a)
  );

  dco_code_slewer #(.STEP_MAX(8)) u_dut_b (
    .clk(clk), .reset_(reset_), .req(req_b), .code_target(ct_b), .fine_target(ft_b),
    .ack(ack_b), .busy(busy_b), .cur_code(cur_b), .coarse_therm(therm_b), .fine_bin(fine_b)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int first_ack;
    int nacks;
    int nbusy;

    // Reset with arbitrary inputs
    reset_ = 1'b1;
    req_a = 1'b1; ct_a = 7'd45; ft_a = 3'd6;
    req_b = 1'b1; ct_b = 7'd99; ft_b = 3'd7;
    tick(3);
    chk("rst_cur", 128'(cur_a), 128'd0);
    chk("rst_therm", 128'(therm_a), 128'd0);
    chk("rst_fine", 128'(fine_a), 128'd0);
    chk("rst_ack", 128'(ack_a), 128'd0);
    chk("rst_busy", 128'(busy_a), 128'd0);
    chk("rst_cur_b", 128'(cur_b), 128'd0);
    req_a = 1'b0; ct_a = 7'd0; ft_a = 3'd0;
    req_b = 1'b0; ct_b = 7'd0; ft_b = 3'd0;
    reset_ = 1'b0;
    tick(2);

    // Up-slew 0 -> 3, fine 5
    ct_a = 7'd3; ft_a = 3'd5; req_a = 1'b1;
    tick(1);
    req_a = 1'b0;
    chk("up_busy_e0", 128'(busy_a), 128'd1);
    chk("up_cur_e0", 128'(cur_a), 128'd0);
    tick(1);
    chk("up_cur_e1", 128'(cur_a), 128'd1);
    chk("up_therm_e1", 128'(therm_a), 128'h1);
    tick(5);
    chk("up_cur_e6", 128'(cur_a), 128'd2);
    chk("up_fine_mid", 128'(fine_a), 128'd0);
    tick(5);
    chk("up_cur_e11", 128'(cur_a), 128'd3);
    tick(4);
    chk("up_ack_e15", 128'(ack_a), 128'd0);
    tick(1);
    chk("up_ack_e16", 128'(ack_a), 128'd1);
    chk("up_therm", 128'(therm_a), 128'h7);
    chk("up_fine", 128'(fine_a), 128'd5);
    chk("up_busy_ack", 128'(busy_a), 128'd0);
    tick(1);
    chk("up_ack_fall", 128'(ack_a), 128'd0);

    // Zero distance
    ct_a = 7'd3; ft_a = 3'd2; req_a = 1'b1;
    tick(1);
    req_a = 1'b0;
    chk("zero_busy", 128'(busy_a), 128'd1);
    chk("zero_fine_hold", 128'(fine_a), 128'd5);
    tick(1);
    chk("zero_ack", 128'(ack_a), 128'd1);
    chk("zero_fine", 128'(fine_a), 128'd2);
    chk("zero_therm", 128'(therm_a), 128'h7);
    tick(1);

    // Busy collision: req to 0 during slew 3 -> 20 is ignored
    ct_a = 7'd20; ft_a = 3'd1; req_a = 1'b1;
    tick(1);
    req_a = 1'b0;
    tick(10);
    ct_a = 7'd0; req_a = 1'b1;
    tick(3);
    req_a = 1'b0;
    first_ack = -1;
    nacks = 0;
    for (int k = 14; k < 120; k++) begin
      tick(1);
      if (ack_a) begin
        nacks++;
        if (first_ack < 0) first_ack = k;
      end
    end
    chk("coll_ack_edge", 128'(first_ack), 128'd86);
    chk("coll_ack_count", 128'(nacks), 128'd1);
    chk("coll_cur", 128'(cur_a), 128'd20);
    chk("coll_busy", 128'(busy_a), 128'd0);

    // Mid-slew reset toward 50
    ct_a = 7'd50; ft_a = 3'd4; req_a = 1'b1;
    tick(1);
    req_a = 1'b0;
    tick(6);
    chk("mrst_cur_2nd", 128'(cur_a), 128'd22);
    tick(1);
    reset_ = 1'b1;
    #1;
    chk("mrst_cur", 128'(cur_a), 128'd0);
    chk("mrst_therm", 128'(therm_a), 128'd0);
    chk("mrst_fine", 128'(fine_a), 128'd0);
    chk("mrst_busy", 128'(busy_a), 128'd0);
    chk("mrst_ack", 128'(ack_a), 128'd0);
    tick(2);
    reset_ = 1'b0;
    nacks = 0;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (ack_a) nacks++;
      if (busy_a) nbusy++;
    end
    chk("mrst_no_ack", 128'(nacks), 128'd0);
    chk("mrst_no_busy", 128'(nbusy), 128'd0);
    chk("mrst_cur_idle", 128'(cur_a), 128'd0);

    // STEP_MAX=8 instance: up to 127, then down to 110
    ct_b = 7'd127; ft_b = 3'd4; req_b = 1'b1;
    tick(1);
    req_b = 1'b0;
    first_ack = -1;
    for (int k = 1; k < 200; k++) begin
      tick(1);
      if (ack_b && first_ack < 0) first_ack = k;
    end
    chk("s8_up_ack_edge", 128'(first_ack), 128'd81);
    chk("s8_up_cur", 128'(cur_b), 128'd127);
    ct_b = 7'd110; ft_b = 3'd3; req_b = 1'b1;
    tick(1);
    req_b = 1'b0;
    tick(1);
    chk("s8_cur_119", 128'(cur_b), 128'd119);
    tick(5);
    chk("s8_cur_111", 128'(cur_b), 128'd111);
    tick(5);
    chk("s8_cur_110", 128'(cur_b), 128'd110);
    tick(4);
    chk("s8_ack_early", 128'(ack_b), 128'd0);
    tick(1);
    chk("s8_ack", 128'(ack_b), 128'd1);
    chk("s8_ones", 128'($countones(therm_b)), 128'd110);
    chk("s8_therm_top", 128'(therm_b[110]), 128'd0);
    chk("s8_fine", 128'(fine_b), 128'd3);
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
